// File: rtl/lcd_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_result_writer
//  Description : Drives the LCD controller handshake. Runs the HD44780 init
//                list after reset, then writes "<op>=<value>" to line 1 on
//                each update request. LCD_WRITER_HEX_EN selects hex output.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_result_writer #(
    parameter int CLR_WAIT = 82000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iUpdate,
    input  logic [7:0] iValue,
    input  logic [1:0] iOp,
    output logic       oBusy,
    output logic       oReady,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone
);
    localparam int c_CNT_W = ($clog2(CLR_WAIT + 1) > 4) ? $clog2(CLR_WAIT + 1) : 4;
    localparam logic [c_CNT_W-1:0] c_CLR_LAST = c_CNT_W'(CLR_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_CONV_LAST = c_CNT_W'(7);

    typedef enum logic [2:0] {
        INIT_ISSUE = 3'd0,
        INIT_WAIT  = 3'd1,
        CLR_DELAY  = 3'd2,
        IDLE       = 3'd3,
        CONVERT    = 3'd4,
        ISSUE      = 3'd5,
        WAIT_DONE  = 3'd6,
        GAP        = 3'd7
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_val;
    logic [1:0]         r_op;
    logic [7:0]         w_init_byte;
    logic [7:0]         w_op_chr;
    logic [7:0]         w_d0;
    logic [7:0]         w_d1;
    logic [7:0]         w_d2;
    logic [7:0]         w_xfer_byte;
    logic               w_xfer_rs;

    always_comb begin
        case (r_idx[1:0])
            2'd0:    w_init_byte = 8'h38;
            2'd1:    w_init_byte = 8'h0C;
            2'd2:    w_init_byte = 8'h01;
            default: w_init_byte = 8'h06;
        endcase
        case (r_op)
            2'd0:    w_op_chr = 8'h2B;
            2'd1:    w_op_chr = 8'h2D;
            2'd2:    w_op_chr = 8'h2A;
            default: w_op_chr = 8'h2F;
        endcase
    end

`ifdef LCD_WRITER_HEX_EN
    function automatic logic [7:0] hex_chr(input logic [3:0] i_n);
        return (i_n < 4'd10) ? {4'h3, i_n} : (8'h37 + {4'h0, i_n});
    endfunction

    always_comb begin
        w_d0 = hex_chr(r_val[7:4]);
        w_d1 = hex_chr(r_val[3:0]);
        w_d2 = 8'h20;
    end
`else
    logic [11:0] r_bcd;
    logic [10:0] w_adj;

    // Hundreds digit is at most 1 before the final shift, so it never needs +3.
    always_comb begin
        w_adj[10:8] = r_bcd[10:8];
        w_adj[7:4]  = (r_bcd[7:4] > 4'd4) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_adj[3:0]  = (r_bcd[3:0] > 4'd4) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_d0        = {4'h3, r_bcd[11:8]};
        w_d1        = {4'h3, r_bcd[7:4]};
        w_d2        = {4'h3, r_bcd[3:0]};
    end
`endif

    always_comb begin
        w_xfer_rs = 1'b1;
        case (r_idx)
            3'd0: begin
                w_xfer_byte = 8'h80;
                w_xfer_rs   = 1'b0;
            end
            3'd1:    w_xfer_byte = w_op_chr;
            3'd2:    w_xfer_byte = 8'h3D;
            3'd3:    w_xfer_byte = w_d0;
            3'd4:    w_xfer_byte = w_d1;
            default: w_xfer_byte = w_d2;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= INIT_ISSUE;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_val   <= 8'h00;
            r_op    <= 2'd0;
`ifndef LCD_WRITER_HEX_EN
            r_bcd   <= 12'h000;
`endif
            oStart  <= 1'b0;
            oDATA   <= 8'h00;
            oRS     <= 1'b0;
            oBusy   <= 1'b1;
            oReady  <= 1'b0;
        end else begin
            case (r_state)
                INIT_ISSUE: begin
                    oDATA   <= w_init_byte;
                    oRS     <= 1'b0;
                    oStart  <= 1'b1;
                    r_state <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (iDone) begin
                        r_cnt   <= '0;
                        r_state <= (r_idx == 3'd2) ? CLR_DELAY : GAP;
                    end
                end
                CLR_DELAY: begin
                    oStart <= 1'b0;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_CLR_LAST) begin
                        r_state <= GAP;
                    end
                end
                IDLE: begin
                    if (iUpdate) begin
                        r_val   <= iValue;
                        r_op    <= iOp;
                        r_cnt   <= '0;
`ifndef LCD_WRITER_HEX_EN
                        r_bcd   <= 12'h000;
`endif
                        oBusy   <= 1'b1;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
`ifdef LCD_WRITER_HEX_EN
                    r_state <= ISSUE;
`else
                    r_bcd <= {w_adj, r_val[7]};
                    r_val <= {r_val[6:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CONV_LAST) begin
                        r_state <= ISSUE;
                    end
`endif
                end
                ISSUE: begin
                    oDATA   <= w_xfer_byte;
                    oRS     <= w_xfer_rs;
                    oStart  <= 1'b1;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (iDone) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    oStart <= 1'b0;
                    // oReady low means the init list is still being walked.
                    if (!oReady && r_idx == 3'd3) begin
                        oReady  <= 1'b1;
                        oBusy   <= 1'b0;
                        r_idx   <= 3'd0;
                        r_state <= IDLE;
                    end else if (oReady && r_idx == 3'd5) begin
                        oBusy   <= 1'b0;
                        r_idx   <= 3'd0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= oReady ? ISSUE : INIT_ISSUE;
                    end
                end
                default: r_state <= INIT_ISSUE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_result_writer
//  Description : Directed bench for lcd_result_writer with an LCD controller
//                model that answers each oStart with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_result_writer;
    localparam int CLR_WAIT = 20;
`ifdef LCD_WRITER_HEX_EN
    localparam int CONV = 1;
`else
    localparam int CONV = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       upd = 1'b0;
    logic [7:0] val = 8'h00;
    logic [1:0] op = 2'd0;
    logic       done_model = 1'b0;
    logic       done_stray = 1'b0;
    logic       done;
    logic       busy;
    logic       ready;
    logic [7:0] data;
    logic       rs;
    logic       start;

    assign done = done_model | done_stray;

    always #5 clk = ~clk;

    lcd_result_writer #(.CLR_WAIT(CLR_WAIT)) u_dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iUpdate (upd),
        .iValue  (val),
        .iOp     (op),
        .oBusy   (busy),
        .oReady  (ready),
        .oDATA   (data),
        .oRS     (rs),
        .oStart  (start),
        .iDone   (done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         low;
        int         at;
    } xfer_t;
    xfer_t mon_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: logs each oStart rise and checks the bus holds while oStart is high.
    logic       mon_prev = 1'b0;
    logic [8:0] mon_held = 9'h000;
    int         low_run  = 0;
    always @(negedge clk) begin
        if (start === 1'b1 && mon_prev !== 1'b1) begin
            mon_q.push_back('{data, rs, low_run, cyc});
            mon_held = {data, rs};
        end else if (start === 1'b1) begin
            check("bus_stable", 32'({data, rs}), 32'(mon_held));
        end
        if (start === 1'b1) low_run = 0;
        else                low_run++;
        mon_prev = start;
    end

    // Controller model: done pulse a fixed delay after each oStart rise.
    initial begin
        logic m_prev = 1'b0;
        int   cd     = 0;
        forever begin
            @(negedge clk);
            done_model = 1'b0;
            if (rst) begin
                cd = 0;
            end else if (start === 1'b1 && !m_prev) begin
                cd = 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) done_model = 1'b1;
            end
            m_prev = (start === 1'b1);
        end
    end

    function automatic logic [7:0] op_chr(input logic [1:0] o);
        case (o)
            2'd0:    return 8'h2B;
            2'd1:    return 8'h2D;
            2'd2:    return 8'h2A;
            default: return 8'h2F;
        endcase
    endfunction

    function automatic logic [7:0] dig_chr(input logic [7:0] v, input int k);
`ifdef LCD_WRITER_HEX_EN
        logic [3:0] n;
        if (k == 2) return 8'h20;
        n = (k == 0) ? v[7:4] : v[3:0];
        return (n < 10) ? 8'(48 + int'(n)) : 8'(55 + int'(n));
`else
        int iv = int'(v);
        if (k == 0) return 8'(48 + iv / 100);
        if (k == 1) return 8'(48 + (iv / 10) % 10);
        return 8'(48 + iv % 10);
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_data"},  32'(data),  32'h00);
        check({tag, "_rs"},    32'(rs),    32'd0);
        check({tag, "_busy"},  32'(busy),  32'd1);
        check({tag, "_ready"}, 32'(ready), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_q(input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (mon_q.size() < n) check("queue_timeout", 32'(mon_q.size()), 32'(n));
    endtask

    // Released reset is already applied; checks the first rise and the whole init list.
    task automatic check_init(input string tag);
        logic [7:0] exp_b[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int k = 0;
        check({tag, "_first_start"}, 32'(start), 32'd1);
        check({tag, "_first_data"},  32'(data),  32'h38);
        while (ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_count"}, 32'(mon_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            check($sformatf("%s_e%0d", tag, i), 32'({mon_q[i].d, mon_q[i].rs}), 32'({exp_b[i], 1'b0}));
        end
        if (mon_q.size() >= 4) begin
            check({tag, "_gap_normal"}, 32'(mon_q[1].low), 32'd1);
            check({tag, "_gap_clear"},  32'(mon_q[3].low), 32'(CLR_WAIT + 1));
        end
    endtask

    int n_edge;

    task automatic start_write(input logic [7:0] v, input logic [1:0] o);
        mon_q.delete();
        val = v;
        op  = o;
        upd = 1'b1;
        @(negedge clk);
        upd    = 1'b0;
        n_edge = cyc;
        val    = ~v;
        op     = ~o;
        check("busy_on_update", 32'(busy), 32'd1);
    endtask

    task automatic finish_write(input logic [7:0] v, input logic [1:0] o, input string tag);
        logic [8:0] exp_e[6];
        exp_e[0] = {8'h80, 1'b0};
        exp_e[1] = {op_chr(o), 1'b1};
        exp_e[2] = {8'h3D, 1'b1};
        for (int k = 0; k < 3; k++) exp_e[3 + k] = {dig_chr(v, k), 1'b1};
        wait_idle(400);
        check({tag, "_count"}, 32'(mon_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            check($sformatf("%s_e%0d", tag, i), 32'({mon_q[i].d, mon_q[i].rs}), 32'(exp_e[i]));
            if (i > 0) check($sformatf("%s_low%0d", tag, i), 32'(mon_q[i].low), 32'd1);
        end
        if (mon_q.size() > 0)
            check({tag, "_latency"}, 32'(mon_q[0].at - n_edge), 32'(CONV + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        mon_q.delete();
        @(negedge clk);
        check_init("init");

        start_write(8'd255, 2'd0);
        finish_write(8'd255, 2'd0, "w255");

        start_write(8'd7, 2'd3);
        finish_write(8'd7, 2'd3, "w7");

        start_write(8'hA5, 2'd2);
        finish_write(8'hA5, 2'd2, "wA5");

        start_write(8'd100, 2'd1);
        wait_q(4, 200);
        val = 8'd9;
        op  = 2'd0;
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        finish_write(8'd100, 2'd1, "w100");
        repeat (30) @(negedge clk);
        check("no_extra_xfer", 32'(mon_q.size()), 32'd6);
        check("still_idle", 32'(busy), 32'd0);

        start_write(8'd42, 2'd0);
        wait_q(3, 200);
        check("eq_entry_active", 32'({start, data}), 32'({1'b1, 8'h3D}));
        rst        = 1'b1;
        done_stray = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        done_stray = 1'b0;
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        mon_q.delete();
        @(negedge clk);
        check_init("reinit");

        start_write(8'd0, 2'd1);
        finish_write(8'd0, 2'd1, "w0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
